// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings for ID-stage branch resolution: branch commands, controller states
// and the per-command operand-read mask.
package branch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_BEZ  = 2'd1,
    COND_BNE  = 2'd2,
    COND_JUMP = 2'd3
  } brComm_t;

  typedef enum logic [1:0] {
    BHC_IDLE    = 2'd0,
    BHC_STALL   = 2'd1,
    BHC_RESOLVE = 2'd2
  } bhcState_t;

  localparam int CNT_W = 2;

  // Bit 0: command reads src1, bit 1: command reads src2.
  function automatic logic [1:0] readMask(input logic [1:0] comm);
    case (comm)
      COND_BNE: return 2'b11;
      COND_BEZ: return 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side bundle for the branch hazard controller: ID/EXE/MEM hazard fields in,
// PC/IF-ID/ID-EXE control out. The pipeline drives master, the controller uses slave.
interface branch_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  freeze;
  logic [1:0]            id_br_comm;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  br_cond;
  logic                  stall;
  logic                  bubble;
  logic                  pc_src;
  logic                  flush_if;

  modport master (
    output freeze, id_br_comm, id_src1, id_src2, exe_dest, exe_wb_en,
           mem_dest, mem_wb_en, br_cond,
    input  stall, bubble, pc_src, flush_if
  );

  modport slave (
    input  freeze, id_br_comm, id_src1, id_src2, exe_dest, exe_wb_en,
           mem_dest, mem_wb_en, br_cond,
    output stall, bubble, pc_src, flush_if
  );
endinterface

// File: rtl/branch_dep_detect.sv
// Combinational RAW check of the ID branch operands against the EXE and MEM writers.
// Register 0 is hard-wired and never creates a dependency.
module branch_dep_detect
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [1:0]            brComm,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_ADDR_W-1:0] exeDest,
  input  logic                  exeWbEn,
  input  logic [REG_ADDR_W-1:0] memDest,
  input  logic                  memWbEn,
  output logic                  exeMatch,
  output logic                  memMatch
);
  logic [1:0] mask;
  logic       useSrc1;
  logic       useSrc2;

  assign mask    = readMask(brComm);
  assign useSrc1 = mask[0] && (src1 != '0);
  assign useSrc2 = mask[1] && (src2 != '0);

  assign exeMatch = exeWbEn && ((useSrc1 && exeDest == src1) || (useSrc2 && exeDest == src2));
  assign memMatch = memWbEn && ((useSrc1 && memDest == src1) || (useSrc2 && memDest == src2));
endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencing: stall until operands reach the write-first register file,
// then resolve (PC select + IF/ID flush). Optional counters under `BR_STATS_EN.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_hazard_ctrl_if.slave    bus
`ifdef BR_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_branches,
  output logic [STAT_W-1:0]      stat_taken,
  output logic [STAT_W-1:0]      stat_stall_cycles
`endif
);
  if (STAT_W < 1) begin : gBadStatW
    $error("STAT_W must be at least 1");
  end

  bhcState_t        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             exeMatch, memMatch;
  logic             stallC, resolveC, takenC;
  logic             hasBranch;

  branch_dep_detect #(.REG_ADDR_W(REG_ADDR_W)) uDepDetect (
    .brComm  (bus.id_br_comm),
    .src1    (bus.id_src1),
    .src2    (bus.id_src2),
    .exeDest (bus.exe_dest),
    .exeWbEn (bus.exe_wb_en),
    .memDest (bus.mem_dest),
    .memWbEn (bus.mem_wb_en),
    .exeMatch(exeMatch),
    .memMatch(memMatch)
  );

  assign hasBranch = (bus.id_br_comm != COND_NONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= BHC_IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // cnt holds the number of STALL-state cycles still to come after the detecting IDLE cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    stateD   = stateQ;
    cntD     = cntQ;
    stallC   = 1'b0;
    resolveC = 1'b0;
    unique case (stateQ)
      BHC_IDLE: begin
        if (hasBranch && exeMatch) begin
          stallC = 1'b1;
          cntD   = CNT_W'(1);
          stateD = BHC_STALL;
        end else if (hasBranch && memMatch) begin
          stallC = 1'b1;
          cntD   = '0;
          stateD = BHC_RESOLVE;
        end else begin
          resolveC = hasBranch;
        end
      end
      BHC_STALL: begin
        stallC = 1'b1;
        cntD   = (cntQ != '0) ? cntQ - CNT_W'(1) : '0;
        if (cntQ <= CNT_W'(1)) stateD = BHC_RESOLVE;
      end
      BHC_RESOLVE: begin
        resolveC = hasBranch;
        stateD   = BHC_IDLE;
      end
      default: stateD = BHC_IDLE;
    endcase
    takenC = resolveC && ((bus.id_br_comm == COND_JUMP) || bus.br_cond);
    if (bus.freeze) begin
      stateD = stateQ;
      cntD   = cntQ;
    end
  end

  // A frozen cycle keeps the stall level but issues no bubble and defers resolution.
  assign bus.stall    = !rst && stallC;
  assign bus.bubble   = !rst && !bus.freeze && stallC;
  assign bus.pc_src   = !rst && !bus.freeze && takenC;
  assign bus.flush_if = !rst && !bus.freeze && takenC;

`ifdef BR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else if (!bus.freeze) begin
      if (resolveC) stat_branches     <= stat_branches + STAT_W'(1);
      if (takenC)   stat_taken        <= stat_taken + STAT_W'(1);
      if (stallC)   stat_stall_cycles <= stat_stall_cycles + STAT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed scoreboard bench for branch_hazard_ctrl; stats checks compile in with BR_STATS_EN.
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;

  localparam int REG_ADDR_W = 5;
  localparam int STAT_W     = 32;

  typedef struct {
    string      tag;
    logic [3:0] v;   // {stall, bubble, pc_src, flush_if}
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  branch_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W)) bus ();

`ifdef BR_STATS_EN
  logic [STAT_W-1:0] statBranches, statTaken, statStallCycles;
`endif

  branch_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .STAT_W(STAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BR_STATS_EN
    ,
    .stat_branches    (statBranches),
    .stat_taken       (statTaken),
    .stat_stall_cycles(statStallCycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input string tag, input logic [1:0] comm,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] ed, input logic ewe,
                      input logic [4:0] md, input logic mwe,
                      input logic bc, input logic frz, input logic [3:0] expV);
    exp_t e;
    logic [3:0] obs;
    bus.id_br_comm = comm;
    bus.id_src1    = s1;
    bus.id_src2    = s2;
    bus.exe_dest   = ed;
    bus.exe_wb_en  = ewe;
    bus.mem_dest   = md;
    bus.mem_wb_en  = mwe;
    bus.br_cond    = bc;
    bus.freeze     = frz;
    sb.push_back('{tag, expV});
    @(negedge clk);
    e   = sb.pop_front();
    obs = {bus.stall, bus.bubble, bus.pc_src, bus.flush_if};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed stall/bubble/pc_src/flush_if=%b expected=%b", e.tag, obs, e.v);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef BR_STATS_EN
  task automatic checkStat(input string tag, input logic [STAT_W-1:0] obs,
                           input logic [STAT_W-1:0] expV);
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expV);
    end
  endtask
`endif

  initial begin
    // Reset held with a hazard present: all outputs must be 0.
    step("reset_outputs", COND_BEZ, 5'd3, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
    rst = 1'b0;

    step("bne_nohaz_taken", COND_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);
    step("idle_none",       COND_NONE, 5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 4'b0000);

    // EXE producer: stall t, t+1; resolve t+2 not taken.
    step("bez_exe_t0",      COND_BEZ, 5'd3, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100);
    step("bez_exe_t1",      COND_BEZ, 5'd3, 5'd0, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 4'b1100);
    step("bez_exe_resolve", COND_BEZ, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step("back_to_idle",    COND_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);

    // MEM producer on src2: stall t only.
    step("bne_mem_t0",      COND_BNE, 5'd4, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'b1100);
    step("bne_mem_resolve", COND_BNE, 5'd4, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);
    step("mem_then_idle",   COND_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // r0 never matches; JUMP reads nothing.
    step("bez_r0_nohaz",    COND_BEZ, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0011);
    step("jump_nohaz",      COND_JUMP, 5'd1, 5'd1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 4'b0011);
    step("bez_src2_ignored", COND_BEZ, 5'd6, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'b0000);

    // EXE and MEM both match: EXE rule wins, two stall cycles.
    step("both_t0",         COND_BNE, 5'd6, 5'd7, 5'd6, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 4'b1100);
    step("both_t1",         COND_BNE, 5'd6, 5'd7, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 4'b1100);
    step("both_resolve",    COND_BNE, 5'd6, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);

    // Freeze for three cycles after the detecting cycle: resolution moves from t+2 to t+5.
    step("frz_t0",          COND_BEZ, 5'd8, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100);
    step("frz_hold1",       COND_BEZ, 5'd8, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 4'b1000);
    step("frz_hold2",       COND_BEZ, 5'd8, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 4'b1000);
    step("frz_hold3",       COND_BEZ, 5'd8, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 4'b1000);
    step("frz_stall",       COND_BEZ, 5'd8, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b1100);
    step("frz_resolve",     COND_BEZ, 5'd8, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);
    step("frz_idle_defer",  COND_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
    step("frz_idle_go",     COND_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);

    // Reset pulse mid-stall: outputs 0, then the pending branch re-evaluates from IDLE.
    step("rst_t0",          COND_BEZ, 5'd9, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100);
    rst = 1'b1;
    step("rst_during",      COND_BEZ, 5'd9, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
    rst = 1'b0;
`ifdef BR_STATS_EN
    checkStat("stat_after_rst", statBranches | statTaken | statStallCycles, '0);
`endif
    step("rst_reeval_t0",   COND_BEZ, 5'd9, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100);
    step("rst_reeval_t1",   COND_BEZ, 5'd9, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 4'b1100);
    step("rst_reeval_res",  COND_BEZ, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0011);

    // Three more branches: 4 resolved since reset, 2 taken, 2 stall cycles.
    step("bne_not_taken",   COND_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step("bez_not_taken",   COND_BEZ, 5'd1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step("jump_taken",      COND_JUMP, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0011);
    step("final_idle",      COND_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

`ifdef BR_STATS_EN
    @(negedge clk);
    checkStat("stat_branches",     statBranches,    STAT_W'(4));
    checkStat("stat_taken",        statTaken,       STAT_W'(2));
    checkStat("stat_stall_cycles", statStallCycles, STAT_W'(2));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
